// File: rtl/gol_engine.sv
// rtl/gol_engine.sv - Conway's Life engine on a torus, double-buffered, one row per cycle, with a pixel renderer.
// The host sees only cur; nxt is built row by row and swapped in with a single COMMIT cycle.
module gol_engine #(
    parameter int COLS       = 20,
    parameter int ROWS       = 15,
    parameter int CELL_SHIFT = 5,
    parameter int XW         = 10,
    parameter int GEN_PERIOD = 2**24,
    parameter int GEN_W      = 16,
    parameter int PRESET     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     step,
    input  logic                     clear,
    input  logic                     seed_we,
    input  logic [$clog2(COLS)-1:0]  seed_col,
    input  logic [$clog2(ROWS)-1:0]  seed_row,
    input  logic                     seed_val,
    output logic                     seed_ready,
    output logic                     busy,
    output logic [GEN_W-1:0]         generation,
    input  logic [XW-1:0]            x,
    input  logic [XW-1:0]            y,
    output logic [7:0]               r,
    output logic [7:0]               g,
    output logic [7:0]               b
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(GEN_PERIOD);
    localparam int NP = 12;
    localparam int PC [NP] = '{4, 5, 4, 5, 8, 8, 8, 15, 16, 14, 15, 16};
    localparam int PR [NP] = '{4, 4, 5, 5, 8, 9, 10, 3, 4, 5, 5, 5};

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_COMMIT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COLS-1:0]    r_cur [ROWS];
    logic [COLS-1:0]    r_nxt [ROWS];
    logic [RW-1:0]      r_row;
    logic [TW-1:0]      r_timer;
    logic [GEN_W-1:0]   r_gen;
    logic [7:0]         r_red;
    logic [7:0]         r_grn;
    logic [7:0]         r_blu;

    logic               w_timer_done;
    logic               w_start;
    logic               w_last_row;
    logic [RW-1:0]      w_row_up;
    logic [RW-1:0]      w_row_dn;
    logic [COLS-1:0]    w_nxt_row;
    logic               w_seed_ok;
    logic [XW-1:0]      w_cx;
    logic [XW-1:0]      w_cy;
    logic               w_in_board;
    logic               w_grid;
    logic               w_alive;
    logic [23:0]        w_rgb;

    function automatic logic [COLS-1:0] preset_row(input int row);
        logic [COLS-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) begin
            if (PRESET != 0 && PR[i] == row && PC[i] < COLS)
                v = v | ({{(COLS-1){1'b0}}, 1'b1} << PC[i]);
        end
        return v;
    endfunction

    // Rotations give each column its west/east neighbour with torus wrap built in.
    function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] up,
                                                 input logic [COLS-1:0] mid,
                                                 input logic [COLS-1:0] dn);
        logic [COLS-1:0] up_w, up_e, mid_w, mid_e, dn_w, dn_e, res;
        logic [3:0]      n;
        up_w  = {up[COLS-2:0], up[COLS-1]};
        up_e  = {up[0], up[COLS-1:1]};
        mid_w = {mid[COLS-2:0], mid[COLS-1]};
        mid_e = {mid[0], mid[COLS-1:1]};
        dn_w  = {dn[COLS-2:0], dn[COLS-1]};
        dn_e  = {dn[0], dn[COLS-1:1]};
        res   = '0;
        for (int c = 0; c < COLS; c++) begin
            n = {3'b0, up_w[c]}  + {3'b0, up[c]} + {3'b0, up_e[c]}
              + {3'b0, mid_w[c]} + {3'b0, mid_e[c]}
              + {3'b0, dn_w[c]}  + {3'b0, dn[c]} + {3'b0, dn_e[c]};
            res[c] = (n == 4'd3) || (mid[c] && n == 4'd2);
        end
        return res;
    endfunction

    assign w_timer_done = (r_timer == TW'(GEN_PERIOD - 1));
    assign w_start      = (r_state == S_IDLE) && !seed_we && (run ? w_timer_done : step);
    assign w_last_row   = (r_row == RW'(ROWS - 1));
    assign w_row_up     = (r_row == '0) ? RW'(ROWS - 1) : r_row - RW'(1);
    assign w_row_dn     = w_last_row ? '0 : r_row + RW'(1);
    assign w_nxt_row    = life_row(r_cur[w_row_up], r_cur[r_row], r_cur[w_row_dn]);
    assign w_seed_ok    = ({{(32-CW){1'b0}}, seed_col} < COLS) && ({{(32-RW){1'b0}}, seed_row} < ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start) w_state_nxt = S_COMPUTE;
                S_COMPUTE: if (w_last_row) w_state_nxt = S_COMMIT;
                S_COMMIT:  w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        seed_ready = 1'b0;
        case (r_state)
            S_IDLE:    seed_ready = 1'b1;
            S_COMPUTE: busy = 1'b1;
            S_COMMIT:  busy = 1'b1;
            default:   seed_ready = 1'b0;
        endcase
    end

    // Timer keeps counting through COMPUTE/COMMIT so the run-mode period is exactly GEN_PERIOD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= '0;
        else if (clear || !run || w_start)
            r_timer <= '0;
        else if (!w_timer_done)
            r_timer <= r_timer + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_cur[i] <= preset_row(i);
                r_nxt[i] <= '0;
            end
            r_row <= '0;
            r_gen <= '0;
        end else if (clear) begin
            for (int i = 0; i < ROWS; i++) begin
                r_cur[i] <= '0;
                r_nxt[i] <= '0;
            end
            r_row <= '0;
            r_gen <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_row <= '0;
                    if (seed_we && w_seed_ok)
                        r_cur[seed_row][seed_col] <= seed_val;
                end
                S_COMPUTE: begin
                    r_nxt[r_row] <= w_nxt_row;
                    r_row        <= w_last_row ? '0 : r_row + RW'(1);
                end
                S_COMMIT: begin
                    for (int i = 0; i < ROWS; i++)
                        r_cur[i] <= r_nxt[i];
                    r_gen <= r_gen + GEN_W'(1);
                end
                default: r_row <= '0;
            endcase
        end
    end

    assign w_cx       = x >> CELL_SHIFT;
    assign w_cy       = y >> CELL_SHIFT;
    assign w_in_board = (w_cx < XW'(COLS)) && (w_cy < XW'(ROWS));
    assign w_grid     = (x[CELL_SHIFT-1:0] == '0) || (y[CELL_SHIFT-1:0] == '0);
    assign w_alive    = w_in_board && r_cur[w_cy[RW-1:0]][w_cx[CW-1:0]];

    always_comb begin
        w_rgb = 24'heaeaea;
        if (!w_in_board)
            w_rgb = 24'h000000;
        else if (w_grid)
            w_rgb = 24'h270f3f;
        else if (w_alive)
            w_rgb = 24'h000000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else begin
            r_red <= w_rgb[23:16];
            r_grn <= w_rgb[15:8];
            r_blu <= w_rgb[7:0];
        end
    end

    assign generation = r_gen;
    assign r          = r_red;
    assign g          = r_grn;
    assign b          = r_blu;

endmodule
